// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//   timer_t     : width of baud-period counts (cycles per bit)
//   TRUE/FALSE  : single-bit logic constants
//   tx_state_e  : frame sequencer states
package uart_pkg;

  localparam int TIMER_W = 16;

  typedef logic [TIMER_W-1:0] timer_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_counter.sv
// Bit-period timer for the UART transmitter.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   enable : count while high; held cleared while low
//   count  : period length in clock cycles
//   ovf    : high on the last cycle of each period (the baud tick)
module uart_tx_counter
  import uart_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  input  timer_t count,
  output logic   ovf
);

  timer_t cnt;

  // Counting 0..count-1 makes every period exactly count cycles long.
  assign ovf = enable && (cnt == count - timer_t'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || ovf) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + timer_t'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional
// even/odd parity bit, one stop bit.
//   clk        : system clock
//   rst        : asynchronous active-low reset (aborts a frame)
//   start      : transmit request, accepted in IDLE when baud_count >= 2
//   data       : payload, captured at accept
//   parity_en  : append parity bit, captured at accept
//   parity_odd : 1 = odd parity, 0 = even, captured at accept
//   baud_count : clock cycles per bit, stable while busy
//   tx         : registered serial line, idle high
//   busy       : registered, high while a frame is in flight
//   done       : registered one-cycle pulse when a frame ends
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  timer_t            baud_count,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic              par_en, par_en_next;
  logic              par_odd, par_odd_next;
  logic              tx_next, busy_next, done_next;
  logic              tick;
  logic              timer_en;
  logic              accept;
  logic [DATA_W-1:0] shreg_rot;

  assign timer_en = (state != IDLE);
  assign accept   = (state == IDLE) && start && (baud_count >= timer_t'(2));

  // Rotate rather than shift: the latched word survives intact, so its
  // XOR is still available when the parity bit is due.
  assign shreg_rot = (shreg >> 1) | (shreg << (DATA_W - 1));

  uart_tx_counter u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (timer_en),
    .count  (baud_count),
    .ovf    (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      par_en  <= FALSE;
      par_odd <= FALSE;
      tx      <= TRUE;
      busy    <= FALSE;
      done    <= FALSE;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      idx     <= idx_next;
      par_en  <= par_en_next;
      par_odd <= par_odd_next;
      tx      <= tx_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    idx_next     = idx;
    par_en_next  = par_en;
    par_odd_next = par_odd;
    tx_next      = tx;
    busy_next    = busy;
    done_next    = FALSE;

    unique case (state)
      IDLE: begin
        tx_next = TRUE;
        if (accept) begin
          state_next   = START;
          shreg_next   = data;
          par_en_next  = parity_en;
          par_odd_next = parity_odd;
          idx_next     = '0;
          tx_next      = FALSE;
          busy_next    = TRUE;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          idx_next   = '0;
          tx_next    = shreg[0];
          shreg_next = shreg_rot;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == IDX_LAST) begin
            idx_next = '0;
            if (par_en) begin
              state_next = PARITY;
              tx_next    = (^shreg) ^ par_odd;
            end else begin
              state_next = STOP;
              tx_next    = TRUE;
            end
          end else begin
            idx_next   = idx + IDX_W'(1);
            tx_next    = shreg[0];
            shreg_next = shreg_rot;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          tx_next    = TRUE;
        end
      end
      STOP: begin
        tx_next = TRUE;
        if (tick) begin
          state_next = IDLE;
          busy_next  = FALSE;
          done_next  = TRUE;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = TRUE;
        busy_next  = FALSE;
      end
    endcase
  end

endmodule
